tablero_buscaminas_fsm: RTL and testbench
=========================================

Name: tablero_buscaminas_fsm

Overview:
- Clocked, parametrised minesweeper board engine; next generation of the combinational 8x8 bomb/perimeter/move helpers.
- Owns the bomb map, neighbour counts and the visible board. Adds pseudo-random bomb placement, one-move-per-handshake play, flag toggling, flood-fill reveal of empty regions, and a registered win/lose status.
- Sits between the input/move decoder and the VGA board renderer. The renderer reads cells through a combinational read port.

Parameters:
- FILAS, 8, board rows (x coordinate, 2..16).
- COLUMNAS, 8, board columns (y coordinate, 2..16).
- NB_W, 7, width of num_bombas and counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a new game (accepted in any state).
- num_bombas  in  NB_W  requested bombs, sampled on start.
- semilla  in  16  LFSR seed, sampled on start; 0 is replaced by 16'hACE1.
- mov_valid  in  1  move request.
- mov_ready  out  1  high only in JUGAR.
- mov_tipo  in  2  1 = reveal, 2 = toggle flag; 0/3 = no-op.
- pos_x  in  4  row of move.
- pos_y  in  4  column of move.
- rd_x, rd_y  in  4 each  read-port address.
- rd_celda  out  4  code of visible cell at (rd_x, rd_y); 0 if address out of range (combinational).
- casillas_libres  out  NB_W  hidden non-bomb cells remaining.
- banderas  out  NB_W  flags currently placed.
- estado  out  2  0 = idle/setup, 1 = playing, 2 = victory, 3 = defeat.
- ocupado  out  1  high in COLOCAR, CONTAR, REVELAR, INUNDAR.

Behaviour:
- Cell codes:
  - 0 = hidden.
  - 1..8 = revealed with that many neighbouring bombs.
  - 9 = revealed, zero neighbours.
  - 14 = flag.
  - 15 = exploded bomb.
- Reset (async) values: state REPOSO, all board/bomb/count arrays 0, casillas_libres 0, banderas 0, estado 0, mov_ready 0, ocupado 0.
- Reset mid-operation aborts immediately to those values.
- start (any state):
  - Latch bombs = clamp(num_bombas, 1, FILAS*COLUMNAS-1).
  - Latch seed; clear all arrays and banderas.
  - Go to COLOCAR next cycle.
  - start dominates a simultaneous mov_valid.
- COLOCAR: one attempt per cycle.
  - LFSR x^16+x^14+x^13+x^11+1 (Fibonacci, shift left) advances every cycle.
  - Candidate x = lfsr[3:0], y = lfsr[7:4].
  - Reject if x>=FILAS, y>=COLUMNAS or cell already bomb; otherwise set bomb and increment placed count.
  - Leave when placed == bombs.
- CONTAR: one cell per cycle in row-major order.
  - Store the 3x3 neighbour bomb count; out-of-range neighbours ignored; bomb cells store 0.
  - FILAS*COLUMNAS cycles.
  - Then casillas_libres = FILAS*COLUMNAS - bombs, estado = 1, go to JUGAR.
- JUGAR: mov_ready = 1; a move is accepted on mov_valid & mov_ready.
  - Out-of-range coordinates or mov_tipo 0/3: consumed, no effect.
  - Flag: hidden -> 14, banderas+1; 14 -> 0, banderas-1; revealed cell: no effect.
  - Reveal on flagged or already revealed cell: no effect.
  - Reveal on hidden bomb: cell -> 15, estado = 3, go to FIN.
  - Reveal on hidden non-bomb: go to REVELAR.
- REVELAR (1 cycle):
  - Write count (or 9 if zero) and decrement casillas_libres.
  - If code 9 go to INUNDAR; else check victory.
- INUNDAR: repeated row-major sweeps, one cell per cycle.
  - A hidden (code 0) non-bomb cell with any 8-neighbour at code 9 is revealed (count or 9), and casillas_libres decrements.
  - Flags are never revealed.
  - A sweep with no change ends the fill; then check victory.
- Victory check: casillas_libres == 0 -> estado = 2, go to FIN; else back to JUGAR.
- FIN: mov_ready 0, board frozen, estado held until start or rst.
- casillas_libres and banderas never wrap; banderas is limited by the hidden-cell count by construction.
- mov_ready is 0 and moves are ignored in every state except JUGAR.

Test Plan:
- rst during COLOCAR -> next cycle estado 0, ocupado 0, rd_celda 0 for all cells.
- start, num_bombas=0 -> exactly 1 bomb placed; casillas_libres=63 on entering JUGAR (8x8). num_bombas=100 -> 63 bombs, casillas_libres=1.
- Fixed seed 16'h1234, 10 bombs: bench reference-model bomb map and counts match the read port after revealing every non-bomb cell; estado=2 after the last reveal.
- Reveal a bomb -> that cell reads 15, estado=3, mov_ready=0; subsequent moves change nothing.
- Reveal a zero-count corner on a 1-bomb board -> flood reveals all 63 non-bomb cells, casillas_libres=0, estado=2. A flag placed beforehand stays 14 and blocks nothing else.
- Flag toggle on (2,3) twice -> 14 then 0, banderas 1 then 0. Reveal of a flagged cell, and moves with pos_x=9 on 8x8, have no effect but are consumed (mov_ready stays high).

Source files
------------

// File: rtl/tablero_buscaminas_fsm.sv
// Minesweeper board engine: LFSR bomb placement, neighbour counting,
// handshaked moves, flag toggling, flood-fill reveal and win/lose status.
module tablero_buscaminas_fsm #(
  parameter int unsigned FILAS    = 8,
  parameter int unsigned COLUMNAS = 8,
  parameter int unsigned NB_W     = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NB_W-1:0] num_bombas,
  input  logic [15:0]     semilla,
  input  logic            mov_valid,
  output logic            mov_ready,
  input  logic [1:0]      mov_tipo,
  input  logic [3:0]      pos_x,
  input  logic [3:0]      pos_y,
  input  logic [3:0]      rd_x,
  input  logic [3:0]      rd_y,
  output logic [3:0]      rd_celda,
  output logic [NB_W-1:0] casillas_libres,
  output logic [NB_W-1:0] banderas,
  output logic [1:0]      estado,
  output logic            ocupado
);

  localparam int unsigned XW       = (FILAS > 1) ? $clog2(FILAS) : 1;
  localparam int unsigned YW       = (COLUMNAS > 1) ? $clog2(COLUMNAS) : 1;
  localparam int unsigned TOTAL    = FILAS * COLUMNAS;
  localparam int unsigned NB_MAX   = (1 << NB_W) - 1;
  localparam logic [NB_W-1:0] MAX_BOMBAS = NB_W'((TOTAL - 1 > NB_MAX) ? NB_MAX : TOTAL - 1);
  localparam logic [NB_W-1:0] TOTAL_NB   = NB_W'(TOTAL);
  localparam logic [4:0]    FILAS_L  = 5'(FILAS);
  localparam logic [4:0]    COLS_L   = 5'(COLUMNAS);
  localparam logic [XW-1:0] X_ULT    = XW'(FILAS - 1);
  localparam logic [YW-1:0] Y_ULT    = YW'(COLUMNAS - 1);
  localparam logic [3:0]    C_OCULTA  = 4'd0;
  localparam logic [3:0]    C_VACIA   = 4'd9;
  localparam logic [3:0]    C_BANDERA = 4'd14;
  localparam logic [3:0]    C_EXPLOTA = 4'd15;

  typedef enum logic [2:0] {REPOSO, COLOCAR, CONTAR, JUGAR, REVELAR, INUNDAR, FIN} fase_t;
  fase_t fase, fase_next;

  logic       bomba   [FILAS][COLUMNAS];
  logic [3:0] cuenta  [FILAS][COLUMNAS];
  logic [3:0] tablero [FILAS][COLUMNAS];

  logic [15:0]     lfsr, lfsr_next;
  logic [NB_W-1:0] bombas, colocadas, bombas_sel, libres_menos;
  logic [XW-1:0]   cx, mx, px, cx_sig;
  logic [YW-1:0]   cy, my, py, cy_sig;
  logic            cambio;
  logic            cand_ok, colocar_fin, ultima, mov_en_rango, acepta, revela_inund;
  logic [3:0]      vecinas, celda_mov, cuenta_mem, codigo_scan;
  logic            vecino_vacio;

  // Shared decode: LFSR step, clamping, scan position, move targets.
  always_comb begin
    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    if (num_bombas == '0)             bombas_sel = NB_W'(1);
    else if (num_bombas > MAX_BOMBAS) bombas_sel = MAX_BOMBAS;
    else                              bombas_sel = num_bombas;
    cand_ok      = ({1'b0, lfsr[3:0]} < FILAS_L) && ({1'b0, lfsr[7:4]} < COLS_L) &&
                   !bomba[XW'(lfsr[3:0])][YW'(lfsr[7:4])];
    colocar_fin  = cand_ok && ((colocadas + NB_W'(1)) == bombas);
    ultima       = (cx == X_ULT) && (cy == Y_ULT);
    cy_sig       = (cy == Y_ULT) ? '0 : cy + YW'(1);
    cx_sig       = (cy == Y_ULT) ? ((cx == X_ULT) ? '0 : cx + XW'(1)) : cx;
    mov_en_rango = ({1'b0, pos_x} < FILAS_L) && ({1'b0, pos_y} < COLS_L);
    px           = XW'(pos_x);
    py           = YW'(pos_y);
    celda_mov    = tablero[px][py];
    acepta       = mov_valid && mov_ready && (fase == JUGAR) && !start;
    cuenta_mem   = cuenta[mx][my];
    libres_menos = (casillas_libres != '0) ? casillas_libres - NB_W'(1) : '0;
    codigo_scan  = (cuenta[cx][cy] == 4'd0) ? C_VACIA : cuenta[cx][cy];
    revela_inund = (tablero[cx][cy] == C_OCULTA) && !bomba[cx][cy] && vecino_vacio;
  end

  // 3x3 neighbourhood of the scan cell: bomb count and "touches an empty cell".
  always_comb begin
    vecinas      = '0;
    vecino_vacio = 1'b0;
    for (int di = -1; di <= 1; di++) begin
      for (int dj = -1; dj <= 1; dj++) begin
        if (!(di == 0 && dj == 0) &&
            (int'(cx) + di >= 0) && (int'(cx) + di < int'(FILAS)) &&
            (int'(cy) + dj >= 0) && (int'(cy) + dj < int'(COLUMNAS))) begin
          vecinas = vecinas + 4'(bomba[XW'(int'(cx) + di)][YW'(int'(cy) + dj)]);
          if (tablero[XW'(int'(cx) + di)][YW'(int'(cy) + dj)] == C_VACIA)
            vecino_vacio = 1'b1;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    fase_next = fase;
    if (start) begin
      fase_next = COLOCAR;
    end else begin
      case (fase)
        COLOCAR: if (colocar_fin) fase_next = CONTAR;
        CONTAR:  if (ultima) fase_next = JUGAR;
        JUGAR: begin
          if (acepta && mov_en_rango && mov_tipo == 2'd1 && celda_mov == C_OCULTA)
            fase_next = bomba[px][py] ? FIN : REVELAR;
        end
        REVELAR: begin
          if (cuenta_mem == 4'd0)         fase_next = INUNDAR;
          else if (libres_menos == '0)    fase_next = FIN;
          else                            fase_next = JUGAR;
        end
        INUNDAR: begin
          if (ultima && !cambio && !revela_inund)
            fase_next = (casillas_libres == '0) ? FIN : JUGAR;
        end
        default: fase_next = fase;
      endcase
    end
  end

  // State register with registered handshake/busy flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fase      <= REPOSO;
      mov_ready <= 1'b0;
      ocupado   <= 1'b0;
    end else begin
      fase      <= fase_next;
      mov_ready <= (fase_next == JUGAR);
      ocupado   <= (fase_next inside {COLOCAR, CONTAR, REVELAR, INUNDAR});
    end
  end

  // Board datapath: bomb map, counts, visible board, counters, status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || start) begin
      for (int i = 0; i < int'(FILAS); i++) begin
        for (int j = 0; j < int'(COLUMNAS); j++) begin
          bomba[XW'(i)][YW'(j)]   <= 1'b0;
          cuenta[XW'(i)][YW'(j)]  <= 4'd0;
          tablero[XW'(i)][YW'(j)] <= 4'd0;
        end
      end
      lfsr            <= (rst || semilla == 16'h0) ? 16'hACE1 : semilla;
      bombas          <= rst ? '0 : bombas_sel;
      colocadas       <= '0;
      casillas_libres <= '0;
      banderas        <= '0;
      estado          <= 2'd0;
      cx              <= '0;
      cy              <= '0;
      mx              <= '0;
      my              <= '0;
      cambio          <= 1'b0;
    end else begin
      case (fase)
        COLOCAR: begin
          lfsr <= lfsr_next;
          if (cand_ok) begin
            bomba[XW'(lfsr[3:0])][YW'(lfsr[7:4])] <= 1'b1;
            colocadas <= colocadas + NB_W'(1);
          end
        end
        CONTAR: begin
          cuenta[cx][cy] <= bomba[cx][cy] ? 4'd0 : vecinas;
          cx <= cx_sig;
          cy <= cy_sig;
          if (ultima) begin
            casillas_libres <= TOTAL_NB - bombas;
            estado          <= 2'd1;
          end
        end
        JUGAR: begin
          if (acepta && mov_en_rango) begin
            if (mov_tipo == 2'd1 && celda_mov == C_OCULTA) begin
              if (bomba[px][py]) begin
                tablero[px][py] <= C_EXPLOTA;
                estado          <= 2'd3;
              end else begin
                mx <= px;
                my <= py;
              end
            end else if (mov_tipo == 2'd2) begin
              if (celda_mov == C_OCULTA) begin
                tablero[px][py] <= C_BANDERA;
                banderas        <= banderas + NB_W'(1);
              end else if (celda_mov == C_BANDERA && banderas != '0) begin
                tablero[px][py] <= C_OCULTA;
                banderas        <= banderas - NB_W'(1);
              end
            end
          end
        end
        REVELAR: begin
          tablero[mx][my] <= (cuenta_mem == 4'd0) ? C_VACIA : cuenta_mem;
          casillas_libres <= libres_menos;
          if (cuenta_mem != 4'd0 && libres_menos == '0) estado <= 2'd2;
          cx     <= '0;
          cy     <= '0;
          cambio <= 1'b0;
        end
        INUNDAR: begin
          if (revela_inund) begin
            tablero[cx][cy] <= codigo_scan;
            casillas_libres <= libres_menos;
          end
          cx <= cx_sig;
          cy <= cy_sig;
          if (ultima) begin
            cambio <= 1'b0;
            if (!cambio && !revela_inund && casillas_libres == '0) estado <= 2'd2;
          end else begin
            cambio <= cambio | revela_inund;
          end
        end
        default: ;
      endcase
    end
  end

  // Renderer read port; out-of-range addresses read as hidden.
  always_comb begin
    rd_celda = 4'd0;
    if (({1'b0, rd_x} < FILAS_L) && ({1'b0, rd_y} < COLS_L))
      rd_celda = tablero[XW'(rd_x)][YW'(rd_y)];
  end

endmodule

// File: tb/tb_tablero_buscaminas_fsm.sv
// Scoreboard bench for tablero_buscaminas_fsm (8x8): stimulus pushes expected
// observations, a monitor pops and compares whenever the engine is not busy.
module tb_tablero_buscaminas_fsm;
  localparam int F = 8;
  localparam int C = 8;
  localparam int NBW = 7;
  localparam int K_CELL = 0, K_EST = 1, K_LIB = 2, K_BAN = 3, K_RDY = 4, K_OCU = 5;

  logic clk = 1'b0;
  logic rst, start, mov_valid, mov_ready, ocupado;
  logic [NBW-1:0] num_bombas, casillas_libres, banderas;
  logic [15:0] semilla;
  logic [1:0] mov_tipo, estado;
  logic [3:0] pos_x, pos_y, rd_x, rd_y, rd_celda;

  always #5 clk = ~clk;

  tablero_buscaminas_fsm #(.FILAS(F), .COLUMNAS(C), .NB_W(NBW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_bombas(num_bombas), .semilla(semilla),
    .mov_valid(mov_valid), .mov_ready(mov_ready), .mov_tipo(mov_tipo),
    .pos_x(pos_x), .pos_y(pos_y), .rd_x(rd_x), .rd_y(rd_y), .rd_celda(rd_celda),
    .casillas_libres(casillas_libres), .banderas(banderas), .estado(estado),
    .ocupado(ocupado)
  );

  typedef struct {
    int    kind;
    int    x;
    int    y;
    int    exp;
    string name;
  } item_t;

  item_t q[$];
  int checks = 0;
  int failures = 0;

  bit mb[F][C];
  int mc[F][C];
  int mv[F][C];

  // ---------------- reference model ----------------
  function automatic void model_place(input logic [15:0] seed, input int n);
    logic [15:0] l;
    int want, placed, x, y;
    for (int i = 0; i < F; i++)
      for (int j = 0; j < C; j++) begin
        mb[i][j] = 1'b0; mc[i][j] = 0; mv[i][j] = 0;
      end
    want = (n < 1) ? 1 : ((n > F*C-1) ? F*C-1 : n);
    l = (seed == 16'h0) ? 16'hACE1 : seed;
    placed = 0;
    for (int it = 0; it < 200000 && placed < want; it++) begin
      x = int'(l[3:0]);
      y = int'(l[7:4]);
      if (x < F && y < C && !mb[x][y]) begin
        mb[x][y] = 1'b1;
        placed++;
      end
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    for (int i = 0; i < F; i++)
      for (int j = 0; j < C; j++)
        if (!mb[i][j])
          for (int a = i-1; a <= i+1; a++)
            for (int b = j-1; b <= j+1; b++)
              if (a >= 0 && a < F && b >= 0 && b < C && mb[a][b]) mc[i][j]++;
  endfunction

  function automatic int code_of(input int x, input int y);
    return (mc[x][y] == 0) ? 9 : mc[x][y];
  endfunction

  function automatic bit has_nb9(input int x, input int y);
    for (int a = x-1; a <= x+1; a++)
      for (int b = y-1; b <= y+1; b++)
        if (a >= 0 && a < F && b >= 0 && b < C && !(a == x && b == y) && mv[a][b] == 9)
          return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reveal(input int x, input int y);
    bit ch;
    if (mb[x][y] || mv[x][y] != 0) return;
    mv[x][y] = code_of(x, y);
    if (mv[x][y] != 9) return;
    ch = 1'b1;
    while (ch) begin
      ch = 1'b0;
      for (int i = 0; i < F; i++)
        for (int j = 0; j < C; j++)
          if (mv[i][j] == 0 && !mb[i][j] && has_nb9(i, j)) begin
            mv[i][j] = code_of(i, j);
            ch = 1'b1;
          end
    end
  endfunction

  function automatic int model_libres();
    int n = 0;
    for (int i = 0; i < F; i++)
      for (int j = 0; j < C; j++)
        if (!mb[i][j] && (mv[i][j] == 0 || mv[i][j] == 14)) n++;
    return n;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic push(input int kind, input int x, input int y, input int e, input string nm);
    item_t it;
    it.kind = kind; it.x = x; it.y = y; it.exp = e; it.name = nm;
    q.push_back(it);
  endtask

  task automatic push_board(input string nm);
    for (int i = 0; i < F; i++)
      for (int j = 0; j < C; j++)
        push(K_CELL, i, j, mv[i][j], nm);
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() > 0) begin
      timeout_fail("scoreboard_drain");
      q.delete();
    end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    while (ocupado && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (ocupado) timeout_fail(nm);
  endtask

  task automatic begin_game(input int nb, input logic [15:0] seed);
    num_bombas = NBW'(nb);
    semilla    = seed;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic do_move(input int tipo, input int x, input int y);
    int n;
    mov_tipo = 2'(tipo); pos_x = 4'(x); pos_y = 4'(y);
    mov_valid = 1'b1;
    n = 0;
    while (!mov_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!mov_ready) timeout_fail("move_handshake");
    else begin
      @(posedge clk); #1;
    end
    mov_valid = 1'b0;
    mov_tipo  = 2'd0;
  endtask

  task automatic poke(input int tipo, input int x, input int y);
    mov_tipo = 2'(tipo); pos_x = 4'(x); pos_y = 4'(y);
    mov_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    mov_valid = 1'b0;
    mov_tipo  = 2'd0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    item_t it;
    int act;
    rd_x = 4'd0;
    rd_y = 4'd0;
    forever begin
      @(negedge clk);
      if (q.size() > 0 && !ocupado && !rst) begin
        it = q.pop_front();
        rd_x = 4'(it.x);
        rd_y = 4'(it.y);
        #1;
        case (it.kind)
          K_CELL:  act = int'(rd_celda);
          K_EST:   act = int'(estado);
          K_LIB:   act = int'(casillas_libres);
          K_BAN:   act = int'(banderas);
          K_RDY:   act = int'(mov_ready);
          default: act = int'(ocupado);
        endcase
        checks++;
        if (act != it.exp) begin
          failures++;
          $display("FAIL %s (kind=%0d x=%0d y=%0d): got %0d, required %0d",
                   it.name, it.kind, it.x, it.y, act, it.exp);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int bx, by, fx, fy, kx, ky, lib;
    bit found;
    rst = 1'b1; start = 1'b0; mov_valid = 1'b0; mov_tipo = 2'd0;
    pos_x = 4'd0; pos_y = 4'd0; num_bombas = '0; semilla = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    push(K_EST, 0, 0, 0, "reset_estado");
    push(K_OCU, 0, 0, 0, "reset_ocupado");
    push(K_RDY, 0, 0, 0, "reset_mov_ready");
    push(K_LIB, 0, 0, 0, "reset_libres");
    push(K_BAN, 0, 0, 0, "reset_banderas");
    push(K_CELL, 0, 0, 0, "reset_cell");
    drain();

    // Reset while placing bombs
    begin_game(10, 16'h1234);
    #2 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_place(16'h0, 1);
    for (int i = 0; i < F; i++) for (int j = 0; j < C; j++) mv[i][j] = 0;
    push(K_EST, 0, 0, 0, "rst_colocar_estado");
    push(K_OCU, 0, 0, 0, "rst_colocar_ocupado");
    push(K_RDY, 0, 0, 0, "rst_colocar_mov_ready");
    push_board("rst_colocar_board");
    drain();

    // Game A: num_bombas=0 -> one bomb, seed 0 -> 16'hACE1
    begin_game(0, 16'h0);
    model_place(16'h0, 0);
    wait_idle(5000, "game_a_setup");
    push(K_LIB, 0, 0, 63, "one_bomb_libres");
    push(K_EST, 0, 0, 1, "one_bomb_estado");
    push(K_RDY, 0, 0, 1, "one_bomb_ready");
    drain();

    do_move(2, 2, 3); wait_idle(100, "flag1");
    push(K_CELL, 2, 3, 14, "flag_on_cell");
    push(K_BAN, 0, 0, 1, "flag_on_banderas");
    drain();
    do_move(2, 2, 3); wait_idle(100, "flag2");
    push(K_CELL, 2, 3, 0, "flag_off_cell");
    push(K_BAN, 0, 0, 0, "flag_off_banderas");
    drain();

    bx = 0; by = 0;
    for (int i = 0; i < F; i++) for (int j = 0; j < C; j++) if (mb[i][j]) begin bx = i; by = j; end
    do_move(2, bx, by); wait_idle(100, "flag_bomb");
    mv[bx][by] = 14;
    do_move(1, bx, by); wait_idle(100, "reveal_flagged");
    push(K_CELL, bx, by, 14, "reveal_flagged_cell");
    push(K_EST, 0, 0, 1, "reveal_flagged_estado");
    push(K_RDY, 0, 0, 1, "reveal_flagged_ready");
    push(K_BAN, 0, 0, 1, "flag_bomb_banderas");
    drain();
    do_move(1, 9, 0); wait_idle(100, "out_of_range");
    do_move(3, 0, 0); wait_idle(100, "noop_tipo");
    push(K_EST, 0, 0, 1, "oor_estado");
    push(K_RDY, 0, 0, 1, "oor_ready");
    push(K_LIB, 0, 0, 63, "oor_libres");
    push(K_CELL, 0, 0, 0, "noop_cell");
    drain();

    found = 1'b0; kx = 0; ky = 0;
    for (int k = 0; k < 4; k++) begin
      fx = (k / 2) * (F - 1);
      fy = (k % 2) * (C - 1);
      if (!found && !mb[fx][fy] && mc[fx][fy] == 0) begin found = 1'b1; kx = fx; ky = fy; end
    end
    do_move(1, kx, ky); wait_idle(3000, "flood");
    model_reveal(kx, ky);
    lib = model_libres();
    push_board("flood_board");
    push(K_LIB, 0, 0, lib, "flood_libres");
    push(K_EST, 0, 0, (lib == 0) ? 2 : 1, "flood_estado");
    push(K_BAN, 0, 0, 1, "flood_banderas");
    push(K_RDY, 0, 0, (lib == 0) ? 0 : 1, "flood_ready");
    drain();

    // Game B: 100 bombs clamp to 63
    begin_game(100, 16'hBEEF);
    model_place(16'hBEEF, 100);
    wait_idle(40000, "game_b_setup");
    push(K_LIB, 0, 0, 1, "clamp_libres");
    push(K_EST, 0, 0, 1, "clamp_estado");
    drain();
    fx = 0; fy = 0;
    for (int i = 0; i < F; i++) for (int j = 0; j < C; j++) if (!mb[i][j]) begin fx = i; fy = j; end
    do_move(1, fx, fy); wait_idle(200, "clamp_reveal");
    model_reveal(fx, fy);
    push(K_CELL, fx, fy, mv[fx][fy], "clamp_free_cell");
    push(K_LIB, 0, 0, 0, "clamp_win_libres");
    push(K_EST, 0, 0, 2, "clamp_win_estado");
    drain();

    // Game C: seed 16'h1234, 10 bombs, reveal every non-bomb cell
    begin_game(10, 16'h1234);
    model_place(16'h1234, 10);
    wait_idle(5000, "game_c_setup");
    push(K_LIB, 0, 0, 54, "seed_libres");
    push(K_EST, 0, 0, 1, "seed_estado");
    drain();
    for (int i = 0; i < F; i++)
      for (int j = 0; j < C; j++)
        if (!mb[i][j] && mv[i][j] == 0) begin
          do_move(1, i, j); wait_idle(3000, "seed_reveal");
          model_reveal(i, j);
          lib = model_libres();
          push(K_LIB, 0, 0, lib, "seed_step_libres");
          push(K_EST, 0, 0, (lib == 0) ? 2 : 1, "seed_step_estado");
          drain();
        end
    push_board("seed_final_board");
    push(K_RDY, 0, 0, 0, "seed_final_ready");
    push(K_CELL, 9, 0, 0, "rd_out_of_range_x");
    push(K_CELL, 0, 9, 0, "rd_out_of_range_y");
    drain();

    // Game D: same map, reveal a bomb
    begin_game(10, 16'h1234);
    model_place(16'h1234, 10);
    wait_idle(5000, "game_d_setup");
    bx = 0; by = 0; found = 1'b0;
    for (int i = 0; i < F; i++)
      for (int j = 0; j < C; j++)
        if (mb[i][j] && !found) begin found = 1'b1; bx = i; by = j; end
    do_move(1, bx, by); wait_idle(100, "boom");
    mv[bx][by] = 15;
    push(K_CELL, bx, by, 15, "boom_cell");
    push(K_EST, 0, 0, 3, "boom_estado");
    push(K_RDY, 0, 0, 0, "boom_ready");
    push(K_LIB, 0, 0, 54, "boom_libres");
    drain();
    fx = (bx + 4) % F;
    poke(1, fx, by);
    poke(2, fx, (by + 3) % C);
    push_board("frozen_board");
    push(K_BAN, 0, 0, 0, "frozen_banderas");
    push(K_EST, 0, 0, 3, "frozen_estado");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
